// File: rtl/as_pack.sv
// Shared constants for the as_gpio register block: register indices,
// reset values and the default geometry used by the address decoder.
package as_pack;

    localparam int nr_gpios        = 8;
    localparam int reg_width       = 64;
    localparam int gpio_addr_width = 4;

    // Register indices, in 64-bit words
    localparam int gpio_id_idx_c   = 0;
    localparam int gpio_dir_idx_c  = 1;
    localparam int gpio_data_idx_c = 2;
    localparam int gpio_ris_idx_c  = 3;
    localparam int gpio_imsc_idx_c = 4;
    localparam int gpio_mis_idx_c  = 5;
    localparam int gpio_nr_regs_c  = 6;

    localparam logic [63:0] gpio_id_rst_c   = 64'h1;
    localparam logic [63:0] gpio_imsc_rst_c = '1;

    // Byte window claimed by the decoder
    localparam logic [31:0] gpio_base_addr_c = 32'hFFFF_FF80;
    localparam logic [31:0] gpio_end_addr_c  = gpio_base_addr_c + 32'(gpio_nr_regs_c * 8) - 32'd1;

endpackage

// File: rtl/as_sync2.sv
// Two-flop synchronizer, parameterised width, synchronous active-high reset.
module as_sync2
    import as_pack::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Capture the asynchronous input, then re-register to settle metastability
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/as_gpio.sv
// Memory-mapped GPIO responder: DIR/DATA registers, synchronized pin inputs
// and an optional rising-edge interrupt block (RIS/IMSC/MIS), enabled with
// the AS_GPIO_IRQ_EN macro. Without it, indices 3..5 read as unmapped and
// irq_o is tied low.
module as_gpio
    import as_pack::*;
#(
    parameter int NR_GPIOS = nr_gpios,
    parameter int DW       = reg_width,
    parameter int AW       = gpio_addr_width
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs_i,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DW-1:0]       wdata_i,
    output logic [DW-1:0]       rdata_o,
    output logic                ack_o,
    input  logic [NR_GPIOS-1:0] gpio_i,
    output logic [NR_GPIOS-1:0] gpio_o,
    output logic [NR_GPIOS-1:0] gpio_oe_o,
    output logic                irq_o
);

    logic [NR_GPIOS-1:0] sync_in;
    logic [NR_GPIOS-1:0] dir_q;
    logic [NR_GPIOS-1:0] data_q;
    logic [NR_GPIOS-1:0] wbits;
    logic [DW-1:0]       rd_val;
    logic                wr_en;
    logic                rd_en;

    // A simultaneous write and read strobe is treated as a write only
    assign wr_en = cs_i & we_i;
    assign rd_en = cs_i & re_i & ~we_i;
    assign wbits = wdata_i[NR_GPIOS-1:0];

    generate
        if (DW > NR_GPIOS) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^wdata_i[DW-1:NR_GPIOS];
        end
    endgenerate

    as_sync2 #(
        .WIDTH (NR_GPIOS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_i),
        .q   (sync_in)
    );

    // Direction and output-latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q  <= '0;
            data_q <= '0;
        end else if (wr_en) begin
            case (addr_i)
                AW'(gpio_dir_idx_c):  dir_q  <= wbits;
                AW'(gpio_data_idx_c): data_q <= wbits;
                default: ;
            endcase
        end
    end

    assign gpio_o    = data_q;
    assign gpio_oe_o = dir_q;

`ifdef AS_GPIO_IRQ_EN
    logic [NR_GPIOS-1:0] prev_q;
    logic [NR_GPIOS-1:0] ris_q;
    logic [NR_GPIOS-1:0] imsc_q;
    logic [NR_GPIOS-1:0] edge_evt;
    logic [NR_GPIOS-1:0] ris_clr;
    logic [NR_GPIOS-1:0] mis;

    assign edge_evt = sync_in & ~prev_q & ~dir_q;
    assign ris_clr  = (wr_en && addr_i == AW'(gpio_ris_idx_c)) ? wbits : '0;
    assign mis      = ris_q & imsc_q;

    // Edge detect, W1C status (a set in the same cycle wins), mask and IRQ
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            ris_q  <= '0;
            imsc_q <= gpio_imsc_rst_c[NR_GPIOS-1:0];
            irq_o  <= 1'b0;
        end else begin
            prev_q <= sync_in;
            ris_q  <= (ris_q & ~ris_clr) | edge_evt;
            if (wr_en && addr_i == AW'(gpio_imsc_idx_c)) begin
                imsc_q <= wbits;
            end
            irq_o <= |mis;
        end
    end
`else
    assign irq_o = 1'b0;
`endif

    // Read-data select; unimplemented bits and unmapped indices return 0
    always_comb begin
        rd_val = '0;
        case (addr_i)
            AW'(gpio_id_idx_c):   rd_val = DW'(gpio_id_rst_c);
            AW'(gpio_dir_idx_c):  rd_val[NR_GPIOS-1:0] = dir_q;
            AW'(gpio_data_idx_c): rd_val[NR_GPIOS-1:0] = (sync_in & ~dir_q) | (data_q & dir_q);
`ifdef AS_GPIO_IRQ_EN
            AW'(gpio_ris_idx_c):  rd_val[NR_GPIOS-1:0] = ris_q;
            AW'(gpio_imsc_idx_c): rd_val[NR_GPIOS-1:0] = imsc_q;
            AW'(gpio_mis_idx_c):  rd_val[NR_GPIOS-1:0] = mis;
`endif
            default: ;
        endcase
    end

    // Bus response: one-cycle ack per access, read data held between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o <= '0;
            ack_o   <= 1'b0;
        end else begin
            ack_o <= cs_i & (we_i | re_i);
            if (rd_en) begin
                rdata_o <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_as_gpio.sv
// Scoreboard bench for as_gpio: each access pushes its expected response,
// a negedge monitor pops and checks ack_o/rdata_o. Pin/IRQ levels are
// checked directly by the stimulus thread.
module tb_as_gpio;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_i;
    logic        we_i;
    logic        re_i;
    logic [3:0]  addr_i;
    logic [63:0] wdata_i;
    logic [63:0] rdata_o;
    logic        ack_o;
    logic [7:0]  gpio_i;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_oe_o;
    logic        irq_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          chk;
        logic [63:0] exp;
        string       name;
    } ent_t;

    ent_t sb[$];

`ifdef AS_GPIO_IRQ_EN
    localparam logic [63:0] IMSC_RST = 64'hFF;
`else
    localparam logic [63:0] IMSC_RST = 64'h0;
`endif

    as_gpio #(
        .NR_GPIOS (8),
        .DW       (64),
        .AW       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_i      (cs_i),
        .we_i      (we_i),
        .re_i      (re_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .ack_o     (ack_o),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; expected response queued at the sampling edge
    task automatic acc(input bit we, input bit re, input int addr, input logic [63:0] wd,
                       input bit chk, input logic [63:0] exp, input string name);
        ent_t e;
        cs_i    = 1'b1;
        we_i    = we;
        re_i    = re;
        addr_i  = 4'(addr);
        wdata_i = wd;
        @(posedge clk);
        e.chk  = chk;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        #1;
        cs_i = 1'b0;
        we_i = 1'b0;
        re_i = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [63:0] exp, input string name);
        acc(1'b0, 1'b1, addr, 64'h0, 1'b1, exp, name);
    endtask

    task automatic wr(input int addr, input logic [63:0] wd, input string name);
        acc(1'b1, 1'b0, addr, wd, 1'b0, 64'h0, name);
    endtask

    // Monitor: every queued access must be acked in the following cycle
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({"ack_", e.name}, {63'h0, ack_o}, 64'h1);
                if (e.chk) check(e.name, rdata_o, e.exp);
            end else if (ack_o !== 1'b0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_ack: got %b expected 0", ack_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cs_i = 1'b0; we_i = 1'b0; re_i = 1'b0;
        addr_i = '0; wdata_i = '0; gpio_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",   {63'h0, ack_o}, 64'h0);
        check("rst_rdata", rdata_o, 64'h0);
        check("rst_gpio_o", {56'h0, gpio_o}, 64'h0);
        check("rst_oe",    {56'h0, gpio_oe_o}, 64'h0);
        check("rst_irq",   {63'h0, irq_o}, 64'h0);
        rst = 1'b0;

        // Reset values of all registers, back-to-back reads
        rd(0, 64'h1, "id");
        rd(1, 64'h0, "dir_rst");
        rd(2, 64'h0, "data_rst");
        rd(3, 64'h0, "ris_rst");
        rd(4, IMSC_RST, "imsc_rst");
        rd(5, 64'h0, "mis_rst");
        check("irq_after_rst", {63'h0, irq_o}, 64'h0);

        // Mixed direction: outputs from latch, inputs from pins
        wr(1, 64'h0F, "dir_wr");
        wr(2, 64'hA5, "data_wr");
        gpio_i = 8'h30;
        check("oe_dir", {56'h0, gpio_oe_o}, 64'h0F);
        check("gpio_out", {56'h0, gpio_o}, 64'hA5);
        idle(3);
        rd(2, 64'h35, "data_mixed");
`ifdef AS_GPIO_IRQ_EN
        rd(3, 64'h30, "ris_mixed");
        check("irq_mixed", {63'h0, irq_o}, 64'h1);
        wr(3, 64'hFF, "ris_clr_all");
        idle(1);
        check("irq_cleared", {63'h0, irq_o}, 64'h0);
`endif
        gpio_i = 8'h00;
        wr(1, 64'h0, "dir_zero");
        wr(2, 64'h0, "data_zero");
        idle(3);

`ifdef AS_GPIO_IRQ_EN
        // Pin 2 rises before edge K: RIS after K+2, irq after K+3
        gpio_i = 8'h04;
        idle(3);
        check("irq_k2", {63'h0, irq_o}, 64'h0);
        rd(3, 64'h04, "ris_edge");
        check("irq_k3", {63'h0, irq_o}, 64'h1);
        wr(3, 64'h04, "ris_w1c");
        check("irq_hold", {63'h0, irq_o}, 64'h1);
        idle(1);
        check("irq_fall", {63'h0, irq_o}, 64'h0);
        rd(3, 64'h0, "ris_after_w1c");

        // Masked edge sets RIS but not MIS/irq until unmasked
        wr(4, 64'h0, "imsc_off");
        gpio_i = 8'h24;
        idle(4);
        rd(3, 64'h20, "ris_masked");
        rd(5, 64'h0, "mis_masked");
        check("irq_masked", {63'h0, irq_o}, 64'h0);
        wr(4, 64'h20, "imsc_bit5");
        idle(1);
        check("irq_unmask", {63'h0, irq_o}, 64'h1);
        rd(5, 64'h20, "mis_unmask");
        wr(3, 64'h20, "ris_clr5");
        wr(4, 64'hFF, "imsc_all");
        idle(1);
        check("irq_clr5", {63'h0, irq_o}, 64'h0);

        // W1C of bit 1 on the same edge that sets it: set wins
        gpio_i = 8'h26;
        idle(2);
        wr(3, 64'h02, "ris_w1c_race");
        rd(3, 64'h02, "ris_set_wins");
        wr(3, 64'hFF, "ris_clr_race");
`else
        wr(4, 64'h0, "imsc_unmapped_wr");
        rd(3, 64'h0, "ris_unmapped");
        rd(4, 64'h0, "imsc_unmapped");
        rd(5, 64'h0, "mis_unmapped");
        check("irq_tied", {63'h0, irq_o}, 64'h0);
`endif

        // we+re together: write happens, rdata held; upper bits ignored
        rd(0, 64'h1, "id_again");
        acc(1'b1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FF3C, 1'b1, 64'h1, "we_re_hold");
        rd(1, 64'h3C, "dir_we_re");
        check("oe_we_re", {56'h0, gpio_oe_o}, 64'h3C);

        // Unmapped and read-only accesses
        wr(9, 64'hFF, "unmapped_wr");
        rd(9, 64'h0, "unmapped_rd");
        wr(0, 64'hFF, "id_wr");
        rd(0, 64'h1, "id_ro");
        rd(1, 64'h3C, "dir_intact");

        // Reset during a read: no ack, everything back to reset values
        gpio_i = 8'h06;
        rst = 1'b1; cs_i = 1'b1; re_i = 1'b1; addr_i = 4'd1;
        @(posedge clk);
        #1;
        cs_i = 1'b0; re_i = 1'b0;
        check("midrst_ack",   {63'h0, ack_o}, 64'h0);
        check("midrst_rdata", rdata_o, 64'h0);
        check("midrst_gpio_o", {56'h0, gpio_o}, 64'h0);
        check("midrst_oe",    {56'h0, gpio_oe_o}, 64'h0);
        check("midrst_irq",   {63'h0, irq_o}, 64'h0);
        rst = 1'b0;
        rd(1, 64'h0, "dir_after_rst");
        rd(4, IMSC_RST, "imsc_after_rst");
`ifdef AS_GPIO_IRQ_EN
        // Pins already high after reset give one edge event
        idle(3);
        rd(3, 64'h06, "ris_after_rst");
`endif
        idle(2);
        check("queue_drain", 64'(sb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
